// File: rtl/pad_cfg_sequencer.sv
// ============================================================================
// Module   : pad_cfg_sequencer
// Purpose  : Per-pad configuration store streamed into the padframe over two
//            serial shift chains. Optional build macro: PAD_CFG_AUTOLOAD_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_cfg_sequencer #(
    parameter int                  NUM_PADS    = 38,
    parameter int                  SPLIT       = 19,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 13'h0403
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        cfg_wr_en,
    input  logic [$clog2(NUM_PADS)-1:0] cfg_wr_addr,
    input  logic [CFG_BITS-1:0]         cfg_wr_data,
    output logic                        cfg_wr_err,
    input  logic [$clog2(NUM_PADS)-1:0] cfg_rd_addr,
    output logic [CFG_BITS-1:0]         cfg_rd_data,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        pads_configured,
    output logic                        serial_clock,
    output logic                        serial_load,
    output logic                        serial_data_1,
    output logic                        serial_data_2
);

    localparam int AW = $clog2(NUM_PADS);
    localparam int L  = (SPLIT > NUM_PADS - SPLIT) ? SPLIT : NUM_PADS - SPLIT;
    localparam int WW = (L > 1) ? $clog2(L) : 1;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DW = $clog2(2 * CLK_DIV);

    localparam logic [DW-1:0] c_div_last = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] c_div_half = DW'(CLK_DIV - 1);
    localparam logic [WW-1:0] c_word_last = WW'(L - 1);
    localparam logic [BW-1:0] c_bit_msb = BW'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CFG_BITS-1:0] r_store [NUM_PADS];
    logic [DW-1:0]       r_div;
    logic [WW-1:0]       r_word;
    logic [BW-1:0]       r_bit;
    logic                r_wr_err;
    logic                r_busy;
    logic                r_done;
    logic                r_cfgd;
    logic                r_sclk;
    logic                r_sload;
    logic                r_sd1;
    logic                r_sd2;

    logic                w_wr_ok;
    logic                w_start;
    logic                w_last_bit;
    logic [WW-1:0]       w_nword;
    logic [BW-1:0]       w_nbit;
    int                  w_i1;
    int                  w_i2;
    logic [CFG_BITS-1:0] w_word1;
    logic [CFG_BITS-1:0] w_word2;

`ifdef PAD_CFG_AUTOLOAD_EN
    logic r_auto;

    // High only in the first cycle after reset, acting as an internal start.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_auto <= 1'b1;
        else          r_auto <= 1'b0;
    end

    assign w_start = start | r_auto;
`else
    assign w_start = start;
`endif

    assign w_wr_ok    = cfg_wr_en && (r_state == S_IDLE) && (int'(cfg_wr_addr) < NUM_PADS);
    assign w_last_bit = (r_word == c_word_last) && (r_bit == '0);
    assign cfg_rd_data = (int'(cfg_rd_addr) < NUM_PADS) ? r_store[cfg_rd_addr] : '0;

    // Next word/bit position and its data; a write landing with start is forwarded.
    always_comb begin
        w_nword = '0;
        w_nbit  = c_bit_msb;
        if (r_state != S_IDLE) begin
            if (r_bit == '0) begin
                w_nword = r_word + 1'b1;
            end else begin
                w_nword = r_word;
                w_nbit  = r_bit - 1'b1;
            end
        end
        w_i1    = L - 1 - int'(w_nword);
        w_i2    = NUM_PADS - L + int'(w_nword);
        w_word1 = '0;
        w_word2 = '0;
        if (w_i1 >= 0 && w_i1 < SPLIT)
            w_word1 = (w_wr_ok && int'(cfg_wr_addr) == w_i1) ? cfg_wr_data : r_store[AW'(w_i1)];
        if (w_i2 >= SPLIT && w_i2 < NUM_PADS)
            w_word2 = (w_wr_ok && int'(cfg_wr_addr) == w_i2) ? cfg_wr_data : r_store[AW'(w_i2)];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_word   <= '0;
            r_bit    <= '0;
            r_wr_err <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cfgd   <= 1'b0;
            r_sclk   <= 1'b0;
            r_sload  <= 1'b0;
            r_sd1    <= 1'b0;
            r_sd2    <= 1'b0;
            for (int i = 0; i < NUM_PADS; i++) r_store[i] <= DEFAULT_CFG;
        end else begin
            r_wr_err <= cfg_wr_en && !w_wr_ok;
            r_done   <= 1'b0;
            if (w_wr_ok) r_store[cfg_wr_addr] <= cfg_wr_data;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_word  <= w_nword;
                        r_bit   <= w_nbit;
                        r_sclk  <= 1'b0;
                        r_sd1   <= w_word1[w_nbit];
                        r_sd2   <= w_word2[w_nbit];
                    end
                end
                S_SHIFT: begin
                    if (r_div == c_div_last) begin
                        r_div  <= '0;
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            r_state <= S_LOAD;
                            r_sload <= 1'b1;
                            r_sd1   <= 1'b0;
                            r_sd2   <= 1'b0;
                        end else begin
                            r_word <= w_nword;
                            r_bit  <= w_nbit;
                            r_sd1  <= w_word1[w_nbit];
                            r_sd2  <= w_word2[w_nbit];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        if (r_div == c_div_half) r_sclk <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_div == c_div_last) begin
                        r_state <= S_IDLE;
                        r_div   <= '0;
                        r_sload <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cfgd  <= 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_wr_err      = r_wr_err;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pads_configured = r_cfgd;
    assign serial_clock    = r_sclk;
    assign serial_load     = r_sload;
    assign serial_data_1   = r_sd1;
    assign serial_data_2   = r_sd2;

endmodule

`default_nettype wire

// File: tb/tb_pad_cfg_sequencer.sv
// ============================================================================
// Module   : tb_pad_cfg_sequencer
// Purpose  : Directed self-checking bench for pad_cfg_sequencer (two geometries)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pad_cfg_sequencer;

    localparam int NP = 38;
    localparam int CB = 13;
    localparam int LA = 19;
    localparam int LB = 28;
    localparam int LAT_A = (LA * CB + 1) * 2 * 2 + 1;
    localparam int LAT_B = (LB * CB + 1) * 2 * 1 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_wr_en, a_start, a_err, a_busy, a_done, a_cfgd, a_sclk, a_load, a_sd1, a_sd2;
    logic [5:0]  a_wr_addr, a_rd_addr;
    logic [12:0] a_wr_data, a_rd_data;
    logic        b_wr_en, b_start, b_err, b_busy, b_done, b_cfgd, b_sclk, b_load, b_sd1, b_sd2;
    logic [5:0]  b_wr_addr, b_rd_addr;
    logic [12:0] b_wr_data, b_rd_data;

    pad_cfg_sequencer u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_wr_en(a_wr_en), .cfg_wr_addr(a_wr_addr), .cfg_wr_data(a_wr_data),
        .cfg_wr_err(a_err), .cfg_rd_addr(a_rd_addr), .cfg_rd_data(a_rd_data),
        .start(a_start), .busy(a_busy), .done(a_done), .pads_configured(a_cfgd),
        .serial_clock(a_sclk), .serial_load(a_load),
        .serial_data_1(a_sd1), .serial_data_2(a_sd2)
    );

    pad_cfg_sequencer #(.SPLIT(10), .CLK_DIV(1)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cfg_wr_en(b_wr_en), .cfg_wr_addr(b_wr_addr), .cfg_wr_data(b_wr_data),
        .cfg_wr_err(b_err), .cfg_rd_addr(b_rd_addr), .cfg_rd_data(b_rd_data),
        .start(b_start), .busy(b_busy), .done(b_done), .pads_configured(b_cfgd),
        .serial_clock(b_sclk), .serial_load(b_load),
        .serial_data_1(b_sd1), .serial_data_2(b_sd2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int s_cyc;
    logic [12:0] ma [NP];
    logic [12:0] mb [NP];

    bit   ac1 [0:1023];
    bit   ac2 [0:1023];
    bit   bc1 [0:1023];
    bit   bc2 [0:1023];
    int   a_n, a_hi, a_nload, a_ndone, a_done_cyc;
    int   b_n, b_hi, b_nload, b_ndone, b_done_cyc;
    logic a_sclk_q = 1'b0;
    logic b_sclk_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        a_n = 0; a_hi = 0; a_nload = 0; a_ndone = 0; a_done_cyc = -1;
        b_n = 0; b_hi = 0; b_nload = 0; b_ndone = 0; b_done_cyc = -1;
    endtask

    // One clock; samples both DUTs 1 ns after the edge, capturing bits on serial_clock rise.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (a_sclk && !a_sclk_q) begin
            if (a_n < 1024) begin ac1[a_n] = a_sd1; ac2[a_n] = a_sd2; end
            a_n++;
        end
        if (b_sclk && !b_sclk_q) begin
            if (b_n < 1024) begin bc1[b_n] = b_sd1; bc2[b_n] = b_sd2; end
            b_n++;
        end
        a_sclk_q = a_sclk;
        b_sclk_q = b_sclk;
        if (a_sclk) a_hi++;
        if (b_sclk) b_hi++;
        if (a_load) a_nload++;
        if (b_load) b_nload++;
        if (a_done) begin a_ndone++; if (a_done_cyc < 0) a_done_cyc = cyc; end
        if (b_done) begin b_ndone++; if (b_done_cyc < 0) b_done_cyc = cyc; end
    endtask

    task automatic wr(input bit sel, input int adr, input logic [12:0] d);
        if (!sel) begin a_wr_en = 1'b1; a_wr_addr = 6'(adr); a_wr_data = d; end
        else      begin b_wr_en = 1'b1; b_wr_addr = 6'(adr); b_wr_data = d; end
        step();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic rd_chk_a(input int adr, input logic [12:0] exp);
        a_rd_addr = 6'(adr);
        #1;
        chk($sformatf("A read pad%0d", adr), 32'(a_rd_data), 32'(exp));
    endtask

    function automatic logic [12:0] exp_word(input logic [12:0] m [NP], input int split,
                                             input int chain, input int k);
        int l;
        int idx;
        l = (split > NP - split) ? split : NP - split;
        if (chain == 1) begin
            idx = l - 1 - k;
            return (idx < split) ? m[idx] : 13'h0;
        end
        idx = NP - l + k;
        return (idx >= split) ? m[idx] : 13'h0;
    endfunction

    task automatic check_words(input bit sel, input int split, input string pfx);
        int l;
        int idx;
        logic [12:0] w1;
        logic [12:0] w2;
        l = (split > NP - split) ? split : NP - split;
        for (int k = 0; k < l; k++) begin
            w1 = '0;
            w2 = '0;
            for (int b = 0; b < CB; b++) begin
                idx = k * CB + b;
                w1 = {w1[11:0], sel ? bc1[idx] : ac1[idx]};
                w2 = {w2[11:0], sel ? bc2[idx] : ac2[idx]};
            end
            if (!sel) begin
                chk($sformatf("%s chain1 word%0d", pfx, k), 32'(w1), 32'(exp_word(ma, split, 1, k)));
                chk($sformatf("%s chain2 word%0d", pfx, k), 32'(w2), 32'(exp_word(ma, split, 2, k)));
            end else begin
                chk($sformatf("%s chain1 word%0d", pfx, k), 32'(w1), 32'(exp_word(mb, split, 1, k)));
                chk($sformatf("%s chain2 word%0d", pfx, k), 32'(w2), 32'(exp_word(mb, split, 2, k)));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_wr_en = 0; a_start = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_wr_en = 0; b_start = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        clr_mon();
        for (int i = 0; i < NP; i++) begin ma[i] = 13'h0403; mb[i] = 13'h0403; end
        repeat (3) step();
        rst = 1'b0;

`ifdef PAD_CFG_AUTOLOAD_EN
        chk("autoload busy at release", 32'(a_busy), 32'd0);
        clr_mon();
        step();
        chk("autoload busy rise", 32'(a_busy), 32'd1);
        repeat (LAT_A + 20) step();
        chk("autoload done count", 32'(a_ndone), 32'd1);
        chk("autoload bit count", 32'(a_n), 32'(LA * CB));
        chk("autoload configured", 32'(a_cfgd), 32'd1);
        check_words(1'b0, 19, "autoload");
`else
        chk("reset busy", 32'(a_busy), 32'd0);
        chk("reset configured", 32'(a_cfgd), 32'd0);
        chk("reset done", 32'(a_done), 32'd0);
        chk("reset serial outs", 32'({a_sclk, a_load, a_sd1, a_sd2, a_err}), 32'd0);
        repeat (20) step();
        chk("no autoload configured", 32'(a_cfgd), 32'd0);
        chk("no autoload busy", 32'(a_busy), 32'd0);
`endif
        for (int i = 0; i < NP; i++) rd_chk_a(i, 13'h0403);
        rd_chk_a(45, 13'h0000);

        // Main stream: boundary pads plus a write landing in the start cycle.
        wr(1'b0, 0, 13'h1ABC);  ma[0]  = 13'h1ABC;
        chk("in-range write err", 32'(a_err), 32'd0);
        wr(1'b0, 37, 13'h0001); ma[37] = 13'h0001;
        wr(1'b0, 18, 13'h0AAA); ma[18] = 13'h0AAA;
        wr(1'b0, 19, 13'h1555); ma[19] = 13'h1555;
        a_wr_en = 1'b1; a_wr_addr = 6'd1; a_wr_data = 13'h0F0F; a_start = 1'b1;
        ma[1] = 13'h0F0F;
        clr_mon();
        s_cyc = cyc;
        step();
        a_wr_en = 1'b0; a_start = 1'b0;
        chk("busy after start", 32'(a_busy), 32'd1);
        repeat (LAT_A + 20) step();
        chk("A done latency", 32'(a_done_cyc - s_cyc), 32'(LAT_A));
        chk("A done count", 32'(a_ndone), 32'd1);
        chk("A load cycles", 32'(a_nload), 32'd4);
        chk("A bit count", 32'(a_n), 32'(LA * CB));
        chk("A sclk high cycles", 32'(a_hi), 32'(LA * CB * 2));
        chk("A configured", 32'(a_cfgd), 32'd1);
        chk("A busy end", 32'(a_busy), 32'd0);
        check_words(1'b0, 19, "A");

        // Write and start while busy are rejected / ignored.
        clr_mon();
        s_cyc = cyc;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (10) step();
        a_wr_en = 1'b1; a_wr_addr = 6'd5; a_wr_data = 13'h1FFF; a_start = 1'b1;
        step();
        a_wr_en = 1'b0; a_start = 1'b0;
        chk("busy write err pulse", 32'(a_err), 32'd1);
        step();
        chk("busy write err clears", 32'(a_err), 32'd0);
        repeat (LAT_A + 10) step();
        chk("busy test done count", 32'(a_ndone), 32'd1);
        chk("busy test latency", 32'(a_done_cyc - s_cyc), 32'(LAT_A));
        chk("busy test bit count", 32'(a_n), 32'(LA * CB));
        rd_chk_a(5, 13'h0403);
        a_wr_en = 1'b1; a_wr_addr = 6'd45; a_wr_data = 13'h1FFF;
        step();
        a_wr_en = 1'b0;
        chk("range write err pulse", 32'(a_err), 32'd1);
        rd_chk_a(45, 13'h0000);
        rd_chk_a(37, 13'h0001);

        // Second geometry: SPLIT=10, CLK_DIV=1, distinct word per pad.
        for (int i = 0; i < NP; i++) begin
            wr(1'b1, i, 13'((i << 7) | (i + 1)));
            mb[i] = 13'((i << 7) | (i + 1));
        end
        clr_mon();
        s_cyc = cyc;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        repeat (LAT_B + 20) step();
        chk("B done latency", 32'(b_done_cyc - s_cyc), 32'(LAT_B));
        chk("B done count", 32'(b_ndone), 32'd1);
        chk("B load cycles", 32'(b_nload), 32'd2);
        chk("B bit count", 32'(b_n), 32'(LB * CB));
        chk("B configured", 32'(b_cfgd), 32'd1);
        check_words(1'b1, 10, "B");

        // Reset in the middle of a shift.
        wr(1'b0, 3, 13'h0123);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (50) step();
        chk("busy mid-shift", 32'(a_busy), 32'd1);
        rst = 1'b1;
        step();
        chk("abort busy", 32'(a_busy), 32'd0);
        chk("abort done", 32'(a_done), 32'd0);
        chk("abort configured", 32'(a_cfgd), 32'd0);
        chk("abort serial outs", 32'({a_sclk, a_load, a_sd1, a_sd2, a_err}), 32'd0);
        rd_chk_a(3, 13'h0403);
        rd_chk_a(0, 13'h0403);
        clr_mon();
        step();
        rst = 1'b0;
        repeat (50) step();
        chk("abort no load", 32'(a_nload), 32'd0);
        chk("abort no done", 32'(a_ndone), 32'd0);
`ifdef PAD_CFG_AUTOLOAD_EN
        chk("post-abort autoload busy", 32'(a_busy), 32'd1);
`else
        chk("post-abort idle", 32'(a_busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
